// File: rtl/cplx_pipe_buf.sv
// Elastic, stallable register pipeline for CH-channel complex beats with valid/ready on both sides.
// Define CPLX_PIPE_OCC_EN to add the registered occupancy output `occ`.
module cplx_pipe_buf #(
  parameter int DATA_W = 32,
  parameter int CH     = 2,
  parameter int DEPTH  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [CH*DATA_W-1:0] in_re,
  input  logic [CH*DATA_W-1:0] in_img,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [CH*DATA_W-1:0] out_re,
  output logic [CH*DATA_W-1:0] out_img
`ifdef CPLX_PIPE_OCC_EN
  ,
  output logic [$clog2(DEPTH+1)-1:0] occ
`endif
);

  localparam int VW = CH * DATA_W;

  logic [DEPTH-1:0]         vld_q, vld_d;
  logic [DEPTH-1:0]         mv;
  logic [DEPTH-1:0][VW-1:0] re_q, re_d;
  logic [DEPTH-1:0][VW-1:0] img_q, img_d;

  // A stage may load when it is empty or its content is moving on; the
  // ripple starts from out_ready at the tail, so bubbles collapse under stall.
  always_comb begin : advance
    logic m;
    m = out_ready;
    mv = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      m = vld_q[k] ? m : 1'b1;
      mv[k] = m;
    end
  end

  always_comb begin
    vld_d    = vld_q;
    re_d     = re_q;
    img_d    = img_q;
    in_ready = mv[0] & ~flush;
    if (mv[0]) begin
      vld_d[0] = in_valid & in_ready;
      if (!flush) begin
        re_d[0]  = in_re;
        img_d[0] = in_img;
      end
    end
    for (int k = 1; k < DEPTH; k++) begin
      if (mv[k]) begin
        vld_d[k] = vld_q[k-1];
        if (!flush) begin
          re_d[k]  = re_q[k-1];
          img_d[k] = img_q[k-1];
        end
      end
    end
    // Flush drops every beat but leaves the data words untouched.
    if (flush) vld_d = '0;
  end

  // stage registers: p0 .. p(DEPTH-1)
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      re_q  <= '0;
      img_q <= '0;
    end else begin
      vld_q <= vld_d;
      re_q  <= re_d;
      img_q <= img_d;
    end
  end

  assign out_valid = vld_q[DEPTH-1];
  assign out_re    = re_q[DEPTH-1];
  assign out_img   = img_q[DEPTH-1];

`ifdef CPLX_PIPE_OCC_EN
  localparam int OW = $clog2(DEPTH + 1);

  logic [OW-1:0] occ_q, occ_d;
  logic          acc, del;

  assign acc = in_valid & in_ready;
  assign del = out_valid & out_ready;

  always_comb begin
    occ_d = occ_q;
    if (flush)            occ_d = '0;
    else if (acc && !del) occ_d = occ_q + 1'b1;
    else if (!acc && del) occ_d = occ_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) occ_q <= '0;
    else     occ_q <= occ_d;
  end

  assign occ = occ_q;
`endif

endmodule

// File: tb/tb_cplx_pipe_buf.sv
// Scoreboard bench: u_a (DATA_W=32, CH=2, DEPTH=3) directed scenarios, u_b (16/1/1) random handshake.
`timescale 1ns/1ps
module tb_cplx_pipe_buf;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, flush;
  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [63:0] a_in_re, a_in_img, a_out_re, a_out_img;
  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [15:0] b_in_re, b_in_img, b_out_re, b_out_img;
`ifdef CPLX_PIPE_OCC_EN
  logic [1:0]  a_occ;
  logic [0:0]  b_occ;
`endif

  cplx_pipe_buf #(.DATA_W(32), .CH(2), .DEPTH(3)) u_a (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_re(a_in_re), .in_img(a_in_img),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_re(a_out_re), .out_img(a_out_img)
`ifdef CPLX_PIPE_OCC_EN
    , .occ(a_occ)
`endif
  );

  cplx_pipe_buf #(.DATA_W(16), .CH(1), .DEPTH(1)) u_b (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_re(b_in_re), .in_img(b_in_img),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_re(b_out_re), .out_img(b_out_img)
`ifdef CPLX_PIPE_OCC_EN
    , .occ(b_occ)
`endif
  );

  typedef struct {
    logic [63:0] re;
    logic [63:0] img;
    int          t;
  } ent_t;

  ent_t qa[$];
  ent_t qb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   mon_en = 1'b0;
  bit   lat_on = 1'b0;
  int   a_cnt = 0;
  int   b_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] bre(input int i);
    return {32'(i * 4 + 2), 32'(i * 4 + 1)};
  endfunction

  function automatic logic [63:0] bim(input int i);
    return {32'(i * 4 + 4), 32'(i * 4 + 3)};
  endfunction

  // Output-side monitors: pop the oldest expected beat on every delivered beat.
  always @(negedge clk) begin : mon_a
    ent_t e;
    if (mon_en) begin
      if (a_out_valid && a_out_ready) begin
        if (qa.size() == 0) begin
          checks++; errors++;
          $display("FAIL a_spurious_out actual=%0h required=no_beat", a_out_re);
        end else begin
          e = qa.pop_front();
          check("a_data", {a_out_re, a_out_img}, {e.re, e.img});
          if (lat_on) check("a_latency", 128'(cyc - e.t), 128'(3));
        end
      end
`ifdef CPLX_PIPE_OCC_EN
      check("a_occ", 128'(a_occ), 128'(a_cnt));
      if (rst || flush) a_cnt = 0;
      else a_cnt += int'(a_in_valid && a_in_ready) - int'(a_out_valid && a_out_ready);
`endif
    end
  end

  always @(negedge clk) begin : mon_b
    ent_t e;
    if (mon_en) begin
      if (b_out_valid && b_out_ready) begin
        if (qb.size() == 0) begin
          checks++; errors++;
          $display("FAIL b_spurious_out actual=%0h required=no_beat", b_out_re);
        end else begin
          e = qb.pop_front();
          check("b_data", {b_out_re, b_out_img}, {e.re[15:0], e.img[15:0]});
        end
      end
`ifdef CPLX_PIPE_OCC_EN
      check("b_occ", 128'(b_occ), 128'(b_cnt));
      if (rst || flush) b_cnt = 0;
      else b_cnt += int'(b_in_valid && b_in_ready) - int'(b_out_valid && b_out_ready);
`endif
    end
  end

  // Present one beat for one cycle; push the expected beat if it was taken.
  task automatic try_a(input int i, output bit acc);
    a_in_valid = 1'b1;
    a_in_re    = bre(i);
    a_in_img   = bim(i);
    @(negedge clk);
    acc = a_in_ready;
    if (acc) qa.push_back('{bre(i), bim(i), cyc});
    @(posedge clk); #1;
  endtask

  task automatic idle_a(input int n);
    a_in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    int idx, n_acc;
    rst = 1'b1; flush = 1'b0;
    a_in_valid = 1'b0; a_in_re = '0; a_in_img = '0; a_out_ready = 1'b0;
    b_in_valid = 1'b0; b_in_re = '0; b_in_img = '0; b_out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    mon_en = 1'b1;
    check("rst_out_valid", 128'(a_out_valid), 128'(0));
    check("rst_out_data", {a_out_re, a_out_img}, 128'(0));
    check("rst_b_out_valid", 128'(b_out_valid), 128'(0));
    rst = 1'b0;
    #1;
    check("rst_in_ready", 128'(a_in_ready), 128'(1));

    // Streaming at full rate: every beat must appear exactly 3 cycles later.
    a_out_ready = 1'b1;
    lat_on = 1'b1;
    for (int i = 0; i < 8; i++) begin
      try_a(i, acc);
      check("stream_in_ready", 128'(acc), 128'(1));
    end
    idle_a(5);
    lat_on = 1'b0;
    check("stream_drained", 128'(qa.size()), 128'(0));

    // Back-pressure: only DEPTH beats fit, output held steady.
    a_out_ready = 1'b0;
    idx = 100; n_acc = 0;
    for (int j = 0; j < 5; j++) begin
      try_a(idx, acc);
      if (acc) begin idx++; n_acc++; end
    end
    check("bp_accepted", 128'(n_acc), 128'(3));
    for (int j = 0; j < 2; j++) begin
      check("bp_out_valid", 128'(a_out_valid), 128'(1));
      check("bp_out_stable", {a_out_re, a_out_img}, {bre(100), bim(100)});
      try_a(idx, acc);
      check("bp_full_in_ready", 128'(acc), 128'(0));
    end
    a_out_ready = 1'b1;
    try_a(idx, acc);
    check("bp_same_cycle_accept", 128'(acc), 128'(1));
    idx++;
    try_a(idx, acc);
    check("bp_next_accept", 128'(acc), 128'(1));
    a_in_valid = 1'b0;
    for (int j = 0; j < 3; j++) begin
      check("bp_consecutive_out", 128'(a_out_valid), 128'(1));
      @(posedge clk); #1;
    end
    idle_a(4);
    check("bp_drained", 128'(qa.size()), 128'(0));

    // Bubble collapse: a lone beat advances to the tail while the output stalls.
    a_out_ready = 1'b0;
    try_a(200, acc);
    a_in_valid = 1'b0;
    check("bub_accept", 128'(acc), 128'(1));
    check("bub_lat1", 128'(a_out_valid), 128'(0));
    @(posedge clk); #1;
    check("bub_lat2", 128'(a_out_valid), 128'(0));
    @(posedge clk); #1;
    check("bub_lat3", 128'(a_out_valid), 128'(1));
    idle_a(4);
    try_a(201, acc);
    check("bub_fill1", 128'(acc), 128'(1));
    try_a(202, acc);
    check("bub_fill2", 128'(acc), 128'(1));
    try_a(203, acc);
    check("bub_full", 128'(acc), 128'(0));
    a_out_ready = 1'b1;
    idle_a(5);
    check("bub_drained", 128'(qa.size()), 128'(0));

    // Flush with two beats in flight.
    a_out_ready = 1'b0;
    try_a(300, acc);
    try_a(301, acc);
    idle_a(3);
`ifdef CPLX_PIPE_OCC_EN
    check("flush_occ_before", 128'(a_occ), 128'(2));
`endif
    flush = 1'b1;
    a_in_valid = 1'b1; a_in_re = bre(302); a_in_img = bim(302);
    @(negedge clk);
    check("flush_in_ready", 128'(a_in_ready), 128'(0));
    check("flush_out_valid_same", 128'(a_out_valid), 128'(1));
    @(posedge clk); #1;
    flush = 1'b0; a_in_valid = 1'b0;
    qa.delete();
    check("flush_out_valid_after", 128'(a_out_valid), 128'(0));
`ifdef CPLX_PIPE_OCC_EN
    check("flush_occ_after", 128'(a_occ), 128'(0));
`endif
    a_out_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      @(posedge clk); #1;
      check("flush_no_old_beat", 128'(a_out_valid), 128'(0));
    end

    // Reset with a full pipeline.
    a_out_ready = 1'b0;
    for (int j = 0; j < 3; j++) try_a(400 + j, acc);
    a_in_valid = 1'b0;
    check("rstmid_full", 128'(a_out_valid), 128'(1));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    qa.delete();
    check("rstmid_out_valid", 128'(a_out_valid), 128'(0));
    check("rstmid_out_data", {a_out_re, a_out_img}, 128'(0));
    check("rstmid_in_ready", 128'(a_in_ready), 128'(1));
    a_out_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      @(posedge clk); #1;
      check("rstmid_no_old_beat", 128'(a_out_valid), 128'(0));
    end

    // Random handshake on the single-stage instance.
    for (int j = 0; j < 1000; j++) begin
      b_in_valid  = 1'($urandom_range(0, 1));
      b_in_re     = 16'($urandom);
      b_in_img    = 16'($urandom);
      b_out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (b_in_valid && b_in_ready) qb.push_back('{64'(b_in_re), 64'(b_in_img), cyc});
      @(posedge clk); #1;
    end
    b_in_valid = 1'b0; b_out_ready = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
    end
    check("rand_drained", 128'(qb.size()), 128'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
